// File: rtl/wash_pkg.sv
// Shared definitions for the wash controller: motor command codes and the
// motor driver state encoding.
package wash_pkg;

    localparam logic [1:0] M_STOP = 2'd0;
    localparam logic [1:0] M_CW   = 2'd1;
    localparam logic [1:0] M_CCW  = 2'd2;
    localparam logic [1:0] M_BAD  = 2'd3;

    typedef enum logic [2:0] {
        OFF   = 3'd0,
        DEAD  = 3'd1,
        CW    = 3'd2,
        CCW   = 3'd3,
        FAULT = 3'd4
    } drv_state_t;

endpackage

// File: rtl/wash_timer.sv
// Saturating counter: counts up and sticks at all-ones, or (DOWN=1) counts
// down and sticks at zero. clr beats load, load beats en.
module wash_timer #(
    parameter int W    = 4,
    parameter bit DOWN = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: default assignment first so every path drives cnt_d; no latch.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            if (DOWN) begin
                if (cnt_q != '0) cnt_d = cnt_q - W'(1);
            end else begin
                if (cnt_q != '1) cnt_d = cnt_q + W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/wash_motor_drv.sv
// Motor command receiver: decodes the registered motor code into H-bridge
// gate enables with enforced dead time, plus completion done/buzz outputs.
module wash_motor_drv
    import wash_pkg::*;
#(
    parameter int DEAD_CYC = 2,
    parameter int BUZZ_CYC = 5,
    parameter int DW       = 4,
    parameter int BW       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] motor,
    input  logic       compl_n,
    output logic       hi_a,
    output logic       lo_a,
    output logic       hi_b,
    output logic       lo_b,
    output logic       fault,
    output logic       done,
    output logic       buzz
);

    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYC - 1);
    localparam logic [BW-1:0] BUZZ_LOAD = BW'(BUZZ_CYC);

    logic [1:0]    motor_q;
    logic          compl_q;
    logic          compl_dly_q;
    logic          done_q;
    drv_state_t    state_q, state_d;
    logic          dead_clr;
    logic [DW-1:0] dead_cnt;
    logic [BW-1:0] buzz_cnt;
    logic          compl_fall;

    // Registered 1->0 transition of compl_q; the extra stage keeps reset from
    // ever looking like a completion.
    assign compl_fall = compl_dly_q & ~compl_q;

    always_comb begin
        state_d  = state_q;
        dead_clr = 1'b0;
        if (motor_q == M_BAD) begin
            state_d = FAULT;
        end else begin
            case (state_q)
                FAULT: if (motor_q == M_STOP) state_d = OFF;
                OFF: begin
                    if (motor_q == M_CW || motor_q == M_CCW) begin
                        state_d  = DEAD;
                        dead_clr = 1'b1;
                    end
                end
                CW: begin
                    if (motor_q == M_STOP) begin
                        state_d = OFF;
                    end else if (motor_q == M_CCW) begin
                        state_d  = DEAD;
                        dead_clr = 1'b1;
                    end
                end
                CCW: begin
                    if (motor_q == M_STOP) begin
                        state_d = OFF;
                    end else if (motor_q == M_CW) begin
                        state_d  = DEAD;
                        dead_clr = 1'b1;
                    end
                end
                DEAD: begin
                    if (dead_cnt == DEAD_LAST) begin
                        if (motor_q == M_CW)       state_d = CW;
                        else if (motor_q == M_CCW) state_d = CCW;
                        else                       state_d = OFF;
                    end
                end
                default: state_d = OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= OFF;
            motor_q     <= M_STOP;
            compl_q     <= 1'b0;
            compl_dly_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            motor_q     <= motor;
            compl_q     <= compl_n;
            compl_dly_q <= compl_q;
            done_q      <= compl_fall;
        end
    end

    wash_timer #(.W(DW), .DOWN(1'b0)) u_dead_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (dead_clr),
        .load     (1'b0),
        .load_val ('0),
        .en       (state_q == DEAD),
        .cnt      (dead_cnt)
    );

    // A new completion reloads the buzzer even while it is still sounding.
    wash_timer #(.W(BW), .DOWN(1'b1)) u_buzz_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (1'b0),
        .load     (compl_fall),
        .load_val (BUZZ_LOAD),
        .en       (1'b1),
        .cnt      (buzz_cnt)
    );

    assign hi_a  = (state_q == CW);
    assign lo_b  = (state_q == CW);
    assign hi_b  = (state_q == CCW);
    assign lo_a  = (state_q == CCW);
    assign fault = (state_q == FAULT);
    assign done  = done_q;
    assign buzz  = (buzz_cnt != '0);

endmodule

// File: tb/tb_wash_motor_drv.sv
// Scoreboard bench for wash_motor_drv: each driven cycle pushes its expected
// outputs, which are popped and compared one edge later.
module tb_wash_motor_drv;

    localparam logic [3:0] G_OFF = 4'b0000;
    localparam logic [3:0] G_CW  = 4'b1001;
    localparam logic [3:0] G_CCW = 4'b0110;

    typedef struct {
        string      tag;
        logic [6:0] v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] motor = 2'd0;
    logic       compl_n = 1'b1;
    logic       hi_a, lo_a, hi_b, lo_b, fault, done, buzz;

    exp_t       exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] prev_g  = 4'b0000;

    wash_motor_drv dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .motor   (motor),
        .compl_n (compl_n),
        .hi_a    (hi_a),
        .lo_a    (lo_a),
        .hi_b    (hi_b),
        .lo_b    (lo_b),
        .fault   (fault),
        .done    (done),
        .buzz    (buzz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] outs();
        return {hi_a, lo_a, hi_b, lo_b, fault, done, buzz};
    endfunction

    // Drive one cycle of stimulus, queue what must be seen after the next
    // rising edge, then pop and compare it.
    task automatic step(input string tag, input logic [1:0] m, input logic c,
                        input logic [3:0] g, input logic f, input logic d, input logic b);
        exp_t e;
        exp_t got_e;
        @(negedge clk);
        motor   = m;
        compl_n = c;
        e.tag = tag;
        e.v   = {g, f, d, b};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            got_e = exp_q.pop_front();
            check(got_e.tag, {25'd0, outs()}, {25'd0, got_e.v});
        end
    endtask

    // Leg shoot-through and direct CW<->CCW adjacency must never be seen.
    always @(negedge clk) begin
        logic [3:0] g;
        g = {hi_a, lo_a, hi_b, lo_b};
        if (rst_n) begin
            check("leg_a_shoot", {31'd0, hi_a & lo_a}, 32'd0);
            check("leg_b_shoot", {31'd0, hi_b & lo_b}, 32'd0);
            check("cw_ccw_adjacent",
                  {31'd0, (prev_g == G_CW && g == G_CCW) || (prev_g == G_CCW && g == G_CW)},
                  32'd0);
        end
        prev_g = g;
    end

    initial begin
        #1 rst_n = 1'b0;
        #3;
        check("reset_outs", {25'd0, outs()}, 32'd0);
        @(posedge clk);
        #1;
        check("reset_outs_clk", {25'd0, outs()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Turn-on from OFF: four edges of all-off, then CW.
        step("on_e1", 2'd1, 1'b1, G_OFF, 0, 0, 0);
        step("on_e2", 2'd1, 1'b1, G_OFF, 0, 0, 0);
        step("on_e3", 2'd1, 1'b1, G_OFF, 0, 0, 0);
        step("on_cw", 2'd1, 1'b1, G_CW,  0, 0, 0);
        step("on_cw_hold", 2'd1, 1'b1, G_CW, 0, 0, 0);

        // Reversal CW -> CCW through two dead cycles.
        step("rev_e1", 2'd2, 1'b1, G_CW,  0, 0, 0);
        step("rev_dead0", 2'd2, 1'b1, G_OFF, 0, 0, 0);
        step("rev_dead1", 2'd2, 1'b1, G_OFF, 0, 0, 0);
        step("rev_ccw", 2'd2, 1'b1, G_CCW, 0, 0, 0);
        step("rev_ccw_hold", 2'd2, 1'b1, G_CCW, 0, 0, 0);

        // Back to CW, then a stop goes straight to OFF.
        step("back_e1", 2'd1, 1'b1, G_CCW, 0, 0, 0);
        step("back_dead0", 2'd1, 1'b1, G_OFF, 0, 0, 0);
        step("back_dead1", 2'd1, 1'b1, G_OFF, 0, 0, 0);
        step("back_cw", 2'd1, 1'b1, G_CW,  0, 0, 0);
        step("stop_e1", 2'd0, 1'b1, G_CW,  0, 0, 0);
        step("stop_off", 2'd0, 1'b1, G_OFF, 0, 0, 0);
        step("restart_e1", 2'd1, 1'b1, G_OFF, 0, 0, 0);
        step("restart_dead0", 2'd1, 1'b1, G_OFF, 0, 0, 0);
        step("restart_dead1", 2'd1, 1'b1, G_OFF, 0, 0, 0);
        step("restart_cw", 2'd1, 1'b1, G_CW,  0, 0, 0);

        // Fault from CCW, sticky under motor=1, cleared by motor=0.
        step("toccw_e1", 2'd2, 1'b1, G_CW,  0, 0, 0);
        step("toccw_dead0", 2'd2, 1'b1, G_OFF, 0, 0, 0);
        step("toccw_dead1", 2'd2, 1'b1, G_OFF, 0, 0, 0);
        step("toccw_ccw", 2'd2, 1'b1, G_CCW, 0, 0, 0);
        step("bad_e1", 2'd3, 1'b1, G_CCW, 0, 0, 0);
        step("bad_fault", 2'd3, 1'b1, G_OFF, 1, 0, 0);
        step("fault_m1_a", 2'd1, 1'b1, G_OFF, 1, 0, 0);
        step("fault_m1_b", 2'd1, 1'b1, G_OFF, 1, 0, 0);
        step("fault_m1_c", 2'd1, 1'b1, G_OFF, 1, 0, 0);
        step("clr_e1", 2'd0, 1'b1, G_OFF, 1, 0, 0);
        step("clr_off", 2'd0, 1'b1, G_OFF, 0, 0, 0);
        step("clr_off_hold", 2'd0, 1'b1, G_OFF, 0, 0, 0);

        // Fault during the last dead cycle wins over the CW exit.
        step("dbad_e1", 2'd1, 1'b1, G_OFF, 0, 0, 0);
        step("dbad_dead0", 2'd1, 1'b1, G_OFF, 0, 0, 0);
        step("dbad_dead1", 2'd3, 1'b1, G_OFF, 0, 0, 0);
        step("dbad_fault", 2'd3, 1'b1, G_OFF, 1, 0, 0);
        step("dbad_clr_e1", 2'd0, 1'b1, G_OFF, 1, 0, 0);
        step("dbad_off", 2'd0, 1'b1, G_OFF, 0, 0, 0);

        // Completion, rising edge ignored, then a restart mid-buzz.
        step("cmp_e1", 2'd0, 1'b0, G_OFF, 0, 0, 0);
        step("cmp_done", 2'd0, 1'b0, G_OFF, 0, 1, 1);
        step("cmp_rise", 2'd0, 1'b1, G_OFF, 0, 0, 1);
        step("cmp2_e1", 2'd0, 1'b0, G_OFF, 0, 0, 1);
        step("cmp2_done", 2'd0, 1'b0, G_OFF, 0, 1, 1);
        step("buzz_r4", 2'd0, 1'b0, G_OFF, 0, 0, 1);
        step("buzz_r3", 2'd0, 1'b0, G_OFF, 0, 0, 1);
        step("buzz_r2", 2'd0, 1'b0, G_OFF, 0, 0, 1);
        step("buzz_r1", 2'd0, 1'b0, G_OFF, 0, 0, 1);
        step("buzz_end", 2'd0, 1'b0, G_OFF, 0, 0, 0);
        step("buzz_idle", 2'd0, 1'b0, G_OFF, 0, 0, 0);

        // Reach CW with the buzzer running, then reset between edges.
        step("rcw_e1", 2'd1, 1'b1, G_OFF, 0, 0, 0);
        step("rcw_e2", 2'd1, 1'b0, G_OFF, 0, 0, 0);
        step("rcw_e3", 2'd1, 1'b0, G_OFF, 0, 1, 1);
        step("rcw_cw", 2'd1, 1'b0, G_CW,  0, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_outs", {25'd0, outs()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_a", 2'd0, 1'b0, G_OFF, 0, 0, 0);
        step("post_rst_b", 2'd0, 1'b0, G_OFF, 0, 0, 0);
        step("post_rst_c", 2'd0, 1'b0, G_OFF, 0, 0, 0);

        check("sb_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wash_motor_drv.md
# wash_motor_drv

Receiving end of the wash controller's motor command interface. It decodes the 2-bit `motor` code into four H-bridge gate enables, and guarantees a dead-time with all gates off before any leg is energised. It flags the undefined code as a sticky fault, and turns the falling edge of `compl_n` into a one-cycle `done` pulse plus a timed `buzz` output. It sits between the wash sequencing FSM and the motor power stage, on the same 1 Hz clock.

## Interface
- `DEAD_CYC`, default 2: cycles in DEAD with all gates off before entering CW/CCW; legal range 1..2^DW-1.
- `BUZZ_CYC`, default 5: cycles `buzz` stays high after completion; legal range 1..2^BW-1.
- `DW`, default 4: dead-time counter width.
- `BW`, default 4: buzzer counter width.
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `motor` in 2: command; 0 stop, 1 clockwise, 2 counterclockwise, 3 undefined.
- `compl_n` in 1: 1 while the cycle is running; a falling edge marks completion.
- `hi_a`, `lo_a`, `hi_b`, `lo_b` out 1 each: H-bridge gate enables.
- `fault` out 1: high while in FAULT.
- `done` out 1: one-cycle pulse on completion.
- `buzz` out 1: high for BUZZ_CYC cycles after completion.

## Operation
- `motor` and `compl_n` are registered once into `motor_q` and `compl_q`. All decisions use the registered copies.
- States:
  - OFF: all gates 0.
  - DEAD: all gates 0; dead counter running.
  - CW: `hi_a=1`, `lo_b=1`.
  - CCW: `hi_b=1`, `lo_a=1`.
  - FAULT: all gates 0, `fault=1`.
- Gate outputs and `fault` are pure decodes of the state register. They never glitch.
- Invariant: `hi_a&lo_a` is never 1 and `hi_b&lo_b` is never 1. CW and CCW are never adjacent states.
- Transitions, evaluated at each rising edge. Priority is top to bottom.
  - Any state with `motor_q==3` goes to FAULT.
  - FAULT: `motor_q==0` goes to OFF; any other value stays in FAULT.
  - OFF: `motor_q` 1 or 2 goes to DEAD and the dead counter is cleared to 0.
  - CW: `motor_q==0` goes directly to OFF. `motor_q==2` goes to DEAD with the counter cleared.
  - CCW: symmetric to CW.
  - DEAD: the counter increments each cycle. When counter==DEAD_CYC-1, the next state is chosen from `motor_q` at that edge: 1 goes to CW, 2 goes to CCW, 0 goes to OFF. Otherwise DEAD is held. Changes to `motor_q` during DEAD only affect the exit target.
- Completion: `done=1` for exactly one cycle when `compl_q` goes 1 to 0. The same edge loads the buzzer counter with BUZZ_CYC, and `buzz` is high while the counter is nonzero. A new falling edge during buzzing reloads BUZZ_CYC, i.e. restarts the buzz. A rising edge of `compl_q` has no effect.
- Counters saturate, never wrap. The dead counter only runs in DEAD. The buzzer counter stops at 0.

## Timing
- Reset, asynchronous: state OFF, all gates 0, `fault=0`, `done=0`, `buzz=0`, `motor_q=0`, `compl_q=0`, both counters 0. The first sample after reset cannot produce `done`.
- Reset asserted mid-operation: gates drop to 0 immediately, without waiting for a clock.
- Command latency:
  - A `motor` change visible before edge k is in `motor_q` after edge k. The state and gates change after edge k+1.
  - Gate turn-off on a stop command: 2 edges.
  - Turn-on from OFF: 2 + DEAD_CYC edges.
  - CW to CCW reversal: gates off after 2 edges; CCW after 2 + DEAD_CYC edges.
- `done` and `buzz` rise 2 edges after `compl_n` falls. `buzz` stays high for exactly BUZZ_CYC cycles.
- Fault entry: 2 edges after `motor=3` is applied. Fault exit: 2 edges after `motor=0` is applied, and the exit passes through OFF.

## Structure
- Shared package `wash_pkg`:
  - Motor codes `M_STOP=0`, `M_CW=1`, `M_CCW=2`, `M_BAD=3`.
  - Driver state enum `drv_state_t {OFF, DEAD, CW, CCW, FAULT}`.
  - The wash FSM uses the same motor codes.
- One sub-module, `wash_timer`, instantiated twice (dead time, buzzer):
  - Parameterised width.
  - Ports: `clk`, `rst_n`, `clr`, `load`, `load_val`, `en`, `cnt`.
  - Saturating behaviour.

## Test plan
- Default parameters, reset released, `motor=1` held: all gates 0 for 4 edges, then `hi_a=lo_b=1`; `hi_b=lo_a=0`.
- In CW, drive `motor=2`: gates all 0 two edges later, for exactly 2 cycles, then `hi_b=lo_a=1`. The assertion checking that no leg has both its gates on never fires.
- In CW, drive `motor=0`: all gates 0 two edges later, with no DEAD visit. Then `motor=1` one cycle later: DEAD lasts 2 cycles before CW.
- `motor=3` from CCW: `fault=1` and gates 0 two edges later. `motor=1` keeps FAULT. `motor=0` gives `fault=0` two edges later and state OFF.
- `compl_n` 1 to 0: `done` high for 1 cycle and `buzz` high for 5 cycles. A second falling edge 3 cycles later (after `compl_n` returns high) gives a second `done` and extends `buzz` to 5 cycles from the restart.
- Assert `rst_n=0` mid-CW between clock edges: gates, `buzz` and `fault` go to 0 asynchronously. After release, no `done` pulse appears while `compl_n` stays 0.
